// File: rtl/ex_hazard_scheduler_if.sv
// ID-stage instruction bus into the EX hazard scheduler, plus its forwarding/stall results.
// The master side is the pipeline front end; the slave side is the scheduler.
interface ex_hazard_scheduler_if #(
   parameter int STALL_CNT_W = 16
);
   logic                   id_valid_i;
   logic [4:0]             id_rs1_i;
   logic [4:0]             id_rs2_i;
   logic [4:0]             id_rd_i;
   logic                   id_uses_rs1_i;
   logic                   id_uses_rs2_i;
   logic                   id_writes_rd_i;
   logic                   id_is_load_i;
   logic                   if_branch_i;
   logic [3:0]             reg_forwarding_type_o;
   logic                   stall_load_o;
   logic                   id_hold_o;
   logic [STALL_CNT_W-1:0] stall_count_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
             id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i, id_is_load_i,
             if_branch_i,
      input  reg_forwarding_type_o, stall_load_o, id_hold_o, stall_count_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i,
             id_uses_rs1_i, id_uses_rs2_i, id_writes_rd_i, id_is_load_i,
             if_branch_i,
      output reg_forwarding_type_o, stall_load_o, id_hold_o, stall_count_o
   );
endinterface

// File: rtl/ex_hazard_scheduler.sv
// EX-stage hazard scheduler: tracks the EX/MEM producers of the ID instruction, picks the
// forwarding code, inserts load-use bubbles and squashes the branch shadow.
module ex_hazard_scheduler #(
   parameter int STALL_CNT_W = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   ex_hazard_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      SRC_N,
      SRC_ONE,
      SRC_TWO,
      SRC_MEM,
      SRC_HAZ
   } src_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       writesRd;
      logic       isLoad;
   } slot_t;

   slot_t                  slot1_q, slot1_d;
   slot_t                  slot2_q, slot2_d;
   logic [1:0]             shadowCnt_q, shadowCnt_d;
   logic [3:0]             fwdCode_q, fwdCode_d;
   logic                   stallLoad_q, stallLoad_d;
   logic [STALL_CNT_W-1:0] stallCount_q, stallCount_d;

   logic       squash;
   logic       idLive;
   logic       bubble;
   logic       codeValid;
   logic [3:0] code;
   src_e       src1;
   src_e       src2;

   // slot1 (EX) shadows slot2 (MEM); a load one stage ahead cannot be forwarded yet
   function automatic src_e resolveSrc(input slot_t s1, input slot_t s2,
                                       input logic [4:0] rs, input logic uses);
      logic m1;
      logic m2;
      m1 = uses && (rs != 5'd0) && s1.valid && s1.writesRd && (s1.rd == rs);
      m2 = uses && (rs != 5'd0) && s2.valid && s2.writesRd && (s2.rd == rs);
      if (m1)      return s1.isLoad ? SRC_HAZ : SRC_ONE;
      else if (m2) return s2.isLoad ? SRC_MEM : SRC_TWO;
      else         return SRC_N;
   endfunction

   always_comb begin
      squash = bus.if_branch_i | (shadowCnt_q != 2'd0);
      idLive = bus.id_valid_i & ~squash;
      src1   = resolveSrc(slot1_q, slot2_q, bus.id_rs1_i, bus.id_uses_rs1_i);
      src2   = resolveSrc(slot1_q, slot2_q, bus.id_rs2_i, bus.id_uses_rs2_i);

      // Pairs absent from the table (any HAZ, MEM with a second forward) force a bubble
      codeValid = 1'b1;
      case ({src1, src2})
         {SRC_ONE, SRC_N  }: code = 4'b0000;
         {SRC_N,   SRC_ONE}: code = 4'b0001;
         {SRC_TWO, SRC_N  }: code = 4'b0010;
         {SRC_N,   SRC_TWO}: code = 4'b0011;
         {SRC_MEM, SRC_N  }: code = 4'b0100;
         {SRC_N,   SRC_MEM}: code = 4'b0101;
         {SRC_ONE, SRC_TWO}: code = 4'b0110;
         {SRC_TWO, SRC_ONE}: code = 4'b0111;
         {SRC_ONE, SRC_ONE}: code = 4'b1000;
         {SRC_TWO, SRC_TWO}: code = 4'b1001;
         {SRC_N,   SRC_N  }: code = 4'b1111;
         default: begin
            code      = 4'b1111;
            codeValid = 1'b0;
         end
      endcase

      bubble = idLive & ~codeValid;

      slot2_d      = slot1_q;
      slot1_d      = '0;
      fwdCode_d    = 4'b1111;
      stallLoad_d  = 1'b0;
      stallCount_d = stallCount_q;
      if (bubble) begin
         stallLoad_d = 1'b1;
         if (stallCount_q != {STALL_CNT_W{1'b1}}) begin
            stallCount_d = stallCount_q + STALL_CNT_W'(1);
         end
      end else begin
         slot1_d.valid    = idLive;
         slot1_d.rd       = bus.id_rd_i;
         slot1_d.writesRd = bus.id_writes_rd_i;
         slot1_d.isLoad   = bus.id_is_load_i;
         fwdCode_d        = idLive ? code : 4'b1111;
      end

      // A branch inside the shadow is already masked in EX, so it does not re-arm
      if (shadowCnt_q != 2'd0) begin
         shadowCnt_d = shadowCnt_q - 2'd1;
      end else if (bus.if_branch_i) begin
         shadowCnt_d = 2'd2;
      end else begin
         shadowCnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         slot1_q      <= '0;
         slot2_q      <= '0;
         shadowCnt_q  <= 2'd0;
         fwdCode_q    <= 4'b1111;
         stallLoad_q  <= 1'b0;
         stallCount_q <= '0;
      end else begin
         slot1_q      <= slot1_d;
         slot2_q      <= slot2_d;
         shadowCnt_q  <= shadowCnt_d;
         fwdCode_q    <= fwdCode_d;
         stallLoad_q  <= stallLoad_d;
         stallCount_q <= stallCount_d;
      end
   end

   assign bus.reg_forwarding_type_o = fwdCode_q;
   assign bus.stall_load_o          = stallLoad_q;
   assign bus.stall_count_o         = stallCount_q;
   assign bus.id_hold_o             = bubble & reset_i;

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Self-checking bench for ex_hazard_scheduler: directed pipeline scenarios then random traffic,
// scored against a producer-distance model of the two instructions ahead of ID.
module tb_ex_hazard_scheduler;

   localparam int W = 16;
   localparam int K_N = 0, K_ONE = 1, K_TWO = 2, K_MEM = 3, K_HAZ = 4;

   typedef struct {
      bit       v;
      bit [4:0] rd;
      bit       w;
      bit       ld;
   } instr_t;

   typedef struct {
      int hold;
      int code;
      int stall;
      int count;
   } expect_t;

   logic clk;
   logic rstN;

   ex_hazard_scheduler_if #(.STALL_CNT_W(W)) bus ();

   ex_hazard_scheduler #(.STALL_CNT_W(W)) dut (
      .clk_i   (clk),
      .reset_i (rstN),
      .bus     (bus.slave)
   );

   int      nChecks = 0;
   int      nFails  = 0;
   expect_t scoreQ[$];

   // Model state: ahead[0] is the instruction one stage in front of ID, ahead[1] two stages
   instr_t  ahead[2];
   int      shadowLeft;
   int      mCode;
   int      mStall;
   int      mCount;

   bit       curV, curU1, curU2, curW, curLd, curBr;
   bit [4:0] curRs1, curRs2, curRd;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      ahead[0]   = '{default: 0};
      ahead[1]   = '{default: 0};
      shadowLeft = 0;
      mCode      = 15;
      mStall     = 0;
      mCount     = 0;
   endfunction

   // Nearest producer wins; its distance and load-ness decide how the operand is obtained
   function automatic int kindOf(input bit [4:0] rs, input bit uses);
      if (!uses || rs == 0) return K_N;
      for (int d = 0; d < 2; d++) begin
         if (ahead[d].v && ahead[d].w && ahead[d].rd == rs) begin
            if (d == 0) return ahead[d].ld ? K_HAZ : K_ONE;
            return ahead[d].ld ? K_MEM : K_TWO;
         end
      end
      return K_N;
   endfunction

   function automatic int codeOf(input int k1, input int k2);
      case (k1 * 10 + k2)
         K_ONE * 10 + K_N:   return 0;
         K_N   * 10 + K_ONE: return 1;
         K_TWO * 10 + K_N:   return 2;
         K_N   * 10 + K_TWO: return 3;
         K_MEM * 10 + K_N:   return 4;
         K_N   * 10 + K_MEM: return 5;
         K_ONE * 10 + K_TWO: return 6;
         K_TWO * 10 + K_ONE: return 7;
         K_ONE * 10 + K_ONE: return 8;
         K_TWO * 10 + K_TWO: return 9;
         K_N   * 10 + K_N:   return 15;
         default:            return -1;
      endcase
   endfunction

   // One clock of the model: push what the DUT must show this cycle, then advance
   function automatic bit modelStep();
      bit      squash;
      bit      live;
      bit      bub;
      int      c;
      expect_t e;
      squash = curBr || (shadowLeft > 0);
      live   = curV && !squash;
      c      = codeOf(kindOf(curRs1, curU1), kindOf(curRs2, curU2));
      bub    = live && (c < 0);
      e.hold  = bub;
      e.code  = mCode;
      e.stall = mStall;
      e.count = mCount;
      scoreQ.push_back(e);
      ahead[1] = ahead[0];
      if (bub) begin
         ahead[0].v = 0;
         mStall     = 1;
         mCode      = 15;
         if (mCount < (1 << W) - 1) mCount++;
      end else begin
         ahead[0].v  = live;
         ahead[0].rd = curRd;
         ahead[0].w  = curW;
         ahead[0].ld = curLd;
         mStall      = 0;
         mCode       = live ? c : 15;
      end
      if (shadowLeft > 0) shadowLeft--;
      else if (curBr)     shadowLeft = 2;
      return bub;
   endfunction

   task automatic driveId(input bit v, input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                          input bit u1, input bit u2, input bit w, input bit ld, input bit br);
      curV = v; curRs1 = rs1; curRs2 = rs2; curRd = rd;
      curU1 = u1; curU2 = u2; curW = w; curLd = ld; curBr = br;
      bus.id_valid_i     = v;
      bus.id_rs1_i       = rs1;
      bus.id_rs2_i       = rs2;
      bus.id_rd_i        = rd;
      bus.id_uses_rs1_i  = u1;
      bus.id_uses_rs2_i  = u2;
      bus.id_writes_rd_i = w;
      bus.id_is_load_i   = ld;
      bus.if_branch_i    = br;
   endtask

   // Presents an instruction and keeps it in ID for as long as the model says it is held
   task automatic applyStimulus(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                                input bit [4:0] rd, input bit u1, input bit u2,
                                input bit w, input bit ld, input bit br);
      bit held;
      int tries;
      tries = 0;
      do begin
         @(posedge clk);
         #1;
         driveId(v, rs1, rs2, rd, u1, u2, w, ld, (tries == 0) ? br : 1'b0);
         held = modelStep();
         tries++;
      end while (held && tries < 4);
      if (held) checkOutput("holdBound", tries, 1);
   endtask

   task automatic expectNow(input string name, input int code, input int stall, input int count);
      @(negedge clk);
      checkOutput({name, ".code"}, int'(bus.reg_forwarding_type_o), code);
      checkOutput({name, ".stall"}, int'(bus.stall_load_o), stall);
      checkOutput({name, ".count"}, int'(bus.stall_count_o), count);
   endtask

   task automatic nop();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: every cycle with a pending expectation is compared at the falling edge
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput("sb.hold", int'(bus.id_hold_o), e.hold);
            checkOutput("sb.code", int'(bus.reg_forwarding_type_o), e.code);
            checkOutput("sb.stall", int'(bus.stall_load_o), e.stall);
            checkOutput("sb.count", int'(bus.stall_count_o), e.count);
         end
      end
   end

   initial begin
      rstN = 1'b0;
      driveId(0, 0, 0, 0, 0, 0, 0, 0, 0);
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset.code", int'(bus.reg_forwarding_type_o), 15);
      checkOutput("reset.stall", int'(bus.stall_load_o), 0);
      checkOutput("reset.count", int'(bus.stall_count_o), 0);
      checkOutput("reset.hold", int'(bus.id_hold_o), 0);
      rstN = 1'b1;

      // ADD x5 ; ADD x6,x5,x1
      applyStimulus(1, 1, 2, 5, 1, 1, 1, 0, 0);
      applyStimulus(1, 5, 1, 6, 1, 1, 1, 0, 0);
      nop();
      expectNow("aluChain", 0, 0, 0);

      // LW x5 ; ADD x7,x1,x5
      applyStimulus(1, 1, 0, 5, 1, 0, 1, 1, 0);
      applyStimulus(1, 1, 5, 7, 1, 1, 1, 0, 0);
      nop();
      expectNow("loadUse", 5, 0, 1);

      // LW x5 ; ADD x9 ; ADD x7,x5,x9
      applyStimulus(1, 1, 0, 5, 1, 0, 1, 1, 0);
      applyStimulus(1, 1, 2, 9, 1, 1, 1, 0, 0);
      applyStimulus(1, 5, 9, 7, 1, 1, 1, 0, 0);
      nop();
      expectNow("memOne", 3, 0, 2);

      // ADD x3 ; ADD x4 ; SUB x8,x4,x3 and the same with x0
      applyStimulus(1, 1, 2, 3, 1, 1, 1, 0, 0);
      applyStimulus(1, 1, 2, 4, 1, 1, 1, 0, 0);
      applyStimulus(1, 4, 3, 8, 1, 1, 1, 0, 0);
      nop();
      expectNow("oneTwo", 6, 0, 2);
      applyStimulus(1, 1, 2, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 1, 2, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 0, 0, 8, 1, 1, 1, 0, 0);
      nop();
      expectNow("zeroReg", 15, 0, 2);

      // Branch shadow with a load-use pair and a second branch inside the shadow
      applyStimulus(1, 1, 0, 5, 1, 0, 1, 1, 1);
      applyStimulus(1, 1, 5, 7, 1, 1, 1, 0, 0);
      applyStimulus(1, 5, 1, 5, 1, 1, 1, 0, 1);
      nop();
      expectNow("shadow", 15, 0, 2);
      applyStimulus(1, 5, 7, 6, 1, 1, 1, 0, 0);
      nop();
      expectNow("afterShadow", 15, 0, 2);

      // Reset while a bubble is in EX
      applyStimulus(1, 1, 0, 5, 1, 0, 1, 1, 0);
      @(posedge clk);
      #1;
      driveId(1, 1, 5, 7, 1, 1, 1, 0, 0);
      void'(modelStep());
      @(posedge clk);
      #1;
      rstN = 1'b0;
      #1;
      scoreQ.delete();
      modelReset();
      checkOutput("midReset.code", int'(bus.reg_forwarding_type_o), 15);
      checkOutput("midReset.stall", int'(bus.stall_load_o), 0);
      checkOutput("midReset.count", int'(bus.stall_count_o), 0);
      checkOutput("midReset.hold", int'(bus.id_hold_o), 0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1, 1, 2, 5, 1, 1, 1, 0, 0);
      applyStimulus(1, 5, 1, 6, 1, 1, 1, 0, 0);
      nop();
      expectNow("postReset", 0, 0, 0);

      // Random traffic over a small register set to provoke dense hazards
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 7) != 0,
                       5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                       5'($urandom_range(0, 4)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 11) == 0);
      end
      nop();
      repeat (2) @(negedge clk);
      checkOutput("drain", scoreQ.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
